// File: rtl/gpio_nios_pio_pkg.sv
// Shared constants for the gpio_nios_pio Avalon-MM GPIO slave: register
// addresses, edge-type encodings and the width limit.
package gpio_nios_pio_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_nios_pio_sync.sv
// Input synchroniser for gpio_nios_pio; with GPIO_NIOS_PIO_IRQ_EN defined it
// also carries the prev_in flop and per-bit edge detect.
module gpio_nios_pio_sync
  import gpio_nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
`ifdef GPIO_NIOS_PIO_IRQ_EN
  output logic [WIDTH-1:0] edges,
`endif
  output logic [WIDTH-1:0] sync_in
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync_in = stage[SYNC_STAGES-1];

`ifdef GPIO_NIOS_PIO_IRQ_EN
  logic [WIDTH-1:0] prev_in;

  always_ff @(posedge clk) begin
    if (reset) prev_in <= '0;
    else       prev_in <= sync_in;
  end

  if (EDGE_TYPE == EDGE_RISING) begin : g_rise
    assign edges = sync_in & ~prev_in;
  end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edges = ~sync_in & prev_in;
  end else begin : g_any
    assign edges = sync_in ^ prev_in;
  end
`endif

endmodule

// File: rtl/gpio_nios_pio.sv
// Parametrised Avalon-MM GPIO slave with per-bit direction and set/clear
// writes. Define GPIO_NIOS_PIO_IRQ_EN for edge capture, IRQ mask and irq.
module gpio_nios_pio
  import gpio_nios_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] rd;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

`ifdef GPIO_NIOS_PIO_IRQ_EN
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
`endif

  gpio_nios_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
`ifdef GPIO_NIOS_PIO_IRQ_EN
    .edges   (edges),
`endif
    .sync_in (sync_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= OUT_RESET;
      dir      <= DIR_RESET;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_DIR:    dir      <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     ;
      endcase
    end
  end

`ifdef GPIO_NIOS_PIO_IRQ_EN
  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  // A new edge is ORed in after the clear so it survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr && address == ADDR_IRQMASK) irq_mask <= wdata;
      edge_cap <= (edge_cap & ~cap_clr) | edges;
    end
  end

  assign irq = |(edge_cap & irq_mask);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA:    rd = (data_out & dir) | (sync_in & ~dir);
      ADDR_DIR:     rd = dir;
`ifdef GPIO_NIOS_PIO_IRQ_EN
      ADDR_IRQMASK: rd = irq_mask;
      ADDR_EDGECAP: rd = edge_cap;
`endif
      default:      rd = '0;
    endcase
    readdata            = '0;
    readdata[WIDTH-1:0] = rd;
  end

  assign out_port = data_out;
  assign oe       = dir;

endmodule

// File: tb/tb_gpio_nios_pio.sv
// Directed self-checking bench for gpio_nios_pio (WIDTH=8, OUT_RESET=A5,
// DIR_RESET=0F); irq checks depend on GPIO_NIOS_PIO_IRQ_EN.
module tb_gpio_nios_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gpio_nios_pio #(
    .WIDTH       (8),
    .OUT_RESET   (8'hA5),
    .DIR_RESET   (8'h0F),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", {24'd0, out_port}, 32'hA5);
    check("rst_oe", {24'd0, oe}, 32'h0F);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_edgecap", 3'd3, 32'h0);
    rd_chk("rst_data", 3'd0, 32'h05);
    reset = 1'b0;

    // DATA, OUTSET, OUTCLR
    wr(3'd0, 32'h3C); check("data_wr", {24'd0, out_port}, 32'h3C);
    wr(3'd4, 32'h81); check("outset", {24'd0, out_port}, 32'hBD);
    wr(3'd5, 32'h0C); check("outclr", {24'd0, out_port}, 32'hB1);
    rd_chk("rd_outset", 3'd4, 32'h0);
    rd_chk("rd_outclr", 3'd5, 32'h0);

    // back-to-back OUTSET then OUTCLR
    @(negedge clk);
    address = 3'd4; writedata = 32'h02; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    address = 3'd5; writedata = 32'h80;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("b2b_setclr", {24'd0, out_port}, 32'h33);

    // write without chipselect is ignored
    @(negedge clk);
    address = 3'd0; writedata = 32'h00; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    check("no_cs", {24'd0, out_port}, 32'h33);

    // direction and mixed DATA read through the synchroniser
    wr(3'd1, 32'hF0); check("dir_oe", {24'd0, oe}, 32'hF0);
    rd_chk("dir_rd", 3'd1, 32'hF0);
    wr(3'd0, 32'hA0);
    in_port = 8'h05;
    @(negedge clk); rd_chk("sync_1cyc", 3'd0, 32'hA0);
    @(negedge clk); rd_chk("sync_2cyc", 3'd0, 32'hA5);

    // reserved addresses
    wr(3'd6, 32'hFF); check("rsv_wr", {24'd0, out_port}, 32'hA0);
    rd_chk("rsv6", 3'd6, 32'h0);
    rd_chk("rsv7", 3'd7, 32'h0);

`ifdef GPIO_NIOS_PIO_IRQ_EN
    wr(3'd3, 32'hFF);
    rd_chk("cap_cleared", 3'd3, 32'h0);
    wr(3'd2, 32'h02);
    rd_chk("mask_rd", 3'd2, 32'h02);
    @(negedge clk); in_port = 8'h02;
    @(negedge clk);
    @(negedge clk); check("irq_early", {31'd0, irq}, 32'd0);
    @(negedge clk); check("irq_set", {31'd0, irq}, 32'd1);
    rd_chk("cap_bit1", 3'd3, 32'h02);
    wr(3'd3, 32'h02);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("cap_clr", 3'd3, 32'h0);

    // edge and clear on the same bit in the same cycle
    @(negedge clk); in_port = 8'h12;
    @(negedge clk);
    wr(3'd3, 32'h10);
    rd_chk("set_wins", 3'd3, 32'h10);
    check("irq_unmasked", {31'd0, irq}, 32'd0);

    // fill EDGECAP for the reset test
    wr(3'd2, 32'hFF);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'hFF;
    repeat (4) @(negedge clk);
    rd_chk("cap_full", 3'd3, 32'hFF);
    check("irq_full", {31'd0, irq}, 32'd1);
`else
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'hFF;
    repeat (4) @(negedge clk);
    check("irq_tied", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'hFF);
    rd_chk("noirq_mask", 3'd2, 32'h0);
    rd_chk("noirq_cap", 3'd3, 32'h0);
`endif

    // reset mid-operation with a pending write
    @(negedge clk);
    reset = 1'b1; address = 3'd0; writedata = 32'h00; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("mid_rst_out", {24'd0, out_port}, 32'hA5);
    check("mid_rst_oe", {24'd0, oe}, 32'h0F);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("mid_rst_mask", 3'd2, 32'h0);
    rd_chk("mid_rst_cap", 3'd3, 32'h0);
    rd_chk("mid_rst_data", 3'd0, 32'h05);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
